// File: rtl/grid_access_arbiter_if.sv
// Request/response bundle between the grid access arbiter, its requesters and the grid BRAM.
interface grid_access_arbiter_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              tg_we;
    logic [ADDR_W-1:0] tg_addr;
    logic [7:0]        tg_input;

    logic              pw_req;
    logic [ADDR_W-1:0] pw_addr;
    logic [7:0]        pw_data;
    logic              pw_ready;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [7:0]        rd_data;

    logic              clear_start;
    logic              clear_busy;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;

    // Arbiter side
    modport slave (
        input  tg_we, tg_addr, tg_input,
        input  pw_req, pw_addr, pw_data,
        output pw_ready,
        input  rd_req, rd_addr,
        output rd_ready, rd_valid, rd_data,
        input  clear_start,
        output clear_busy,
        output mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    // Requester and memory side
    modport master (
        output tg_we, tg_addr, tg_input,
        output pw_req, pw_addr, pw_data,
        input  pw_ready,
        output rd_req, rd_addr,
        input  rd_ready, rd_valid, rd_data,
        output clear_start,
        input  clear_busy,
        input  mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/grid_access_arbiter.sv
// Single-port character-grid BRAM arbiter: terminal writes first, round-robin between
// processor writes and reads, plus a full-grid clear sweep.
module grid_access_arbiter #(
    parameter int unsigned SCREEN_WIDTH  = 76,
    parameter int unsigned SCREEN_HEIGHT = 256,
    parameter int unsigned READ_LATENCY  = 2,
    parameter logic [7:0]  CLEAR_CHAR    = 8'h00
) (
    input  logic                  pixel_clk_in,
    input  logic                  rst_in,
    grid_access_arbiter_if.slave  bus
);
    localparam int unsigned DEPTH  = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned VLD_W  = READ_LATENCY + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rr_rd_q, rr_rd_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_din_q, mem_din_d;
    logic [VLD_W-1:0]    vld_q, vld_d;
    logic                busy_q, busy_d;

    logic pw_ready_c, rd_ready_c;
    logic pw_acc_c, rd_acc_c;

    // Grant selection, memory command and sweep sequencing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_rd_d    = rr_rd_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        pw_ready_c = 1'b0;
        rd_ready_c = 1'b0;

        if (state_q == ST_IDLE && !bus.tg_we) begin
            if (bus.pw_req && bus.rd_req) begin
                pw_ready_c = !rr_rd_q;
                rd_ready_c = rr_rd_q;
            end else begin
                pw_ready_c = bus.pw_req;
                rd_ready_c = bus.rd_req;
            end
        end
        pw_acc_c = pw_ready_c & bus.pw_req;
        rd_acc_c = rd_ready_c & bus.rd_req;

        if (bus.tg_we) begin
            mem_we_d   = 1'b1;
            mem_addr_d = bus.tg_addr;
            mem_din_d  = bus.tg_input;
        end else if (state_q == ST_CLEAR) begin
            mem_we_d   = 1'b1;
            mem_addr_d = cnt_q;
            mem_din_d  = CLEAR_CHAR;
        end else if (pw_acc_c) begin
            mem_we_d   = 1'b1;
            mem_addr_d = bus.pw_addr;
            mem_din_d  = bus.pw_data;
            rr_rd_d    = 1'b1;
        end else if (rd_acc_c) begin
            mem_addr_d = bus.rd_addr;
            rr_rd_d    = 1'b0;
        end

        // A terminal write during the sweep steals the slot, so the counter holds
        case (state_q)
            ST_IDLE: begin
                if (bus.clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (!bus.tg_we) begin
                    if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
                    else                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CLEAR);
        vld_d  = {vld_q[VLD_W-2:0], rd_acc_c};
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rr_rd_q    <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            vld_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_rd_q    <= rr_rd_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.pw_ready   = pw_ready_c;
    assign bus.rd_ready   = rd_ready_c;
    assign bus.rd_valid   = vld_q[VLD_W-1];
    assign bus.rd_data    = bus.mem_dout;
    assign bus.clear_busy = busy_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
endmodule

// File: tb/tb_grid_access_arbiter.sv
// Directed and randomized bench for grid_access_arbiter against a rule-level model
// and a two-cycle BRAM model.
module tb_grid_access_arbiter;
    localparam int unsigned DEPTH  = 19456;
    localparam int unsigned ADDR_W = 15;

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  data;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    grid_access_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    grid_access_arbiter #(
        .SCREEN_WIDTH (76),
        .SCREEN_HEIGHT(256),
        .READ_LATENCY (2),
        .CLEAR_CHAR   (8'h00)
    ) dut (
        .pixel_clk_in(clk),
        .rst_in      (rst),
        .bus         (bus)
    );

    // Grid BRAM with two cycles of read latency
    logic [7:0] bram [DEPTH];
    logic [7:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_din;
        rd_p1 <= bram[bus.mem_addr];
        rd_p2 <= rd_p1;
    end
    assign bus.mem_dout = rd_p2;

    // Reference model state
    logic [7:0]        shadow [DEPTH];
    rd_t               rq [$];
    bit                m_clear  = 1'b0;
    int unsigned       m_idx    = 0;
    bit                m_ptr_rd = 1'b0;
    logic [ADDR_W-1:0] m_last   = '0;
    int unsigned       cyc      = 0;
    int                n_pass   = 0;
    int                n_total  = 0;
    int                n_fail   = 0;
    int                n_we     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle_in();
        bus.tg_we = 1'b0; bus.tg_addr = '0; bus.tg_input = '0;
        bus.pw_req = 1'b0; bus.pw_addr = '0; bus.pw_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.clear_start = 1'b0;
    endtask

    // One clock: predict from the rules, check readies before the edge and registered outputs after
    task automatic tick();
        logic              g_pw, g_rd, e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [7:0]        e_din;
        rd_t               ent;
        #1;
        g_pw = 1'b0; g_rd = 1'b0;
        e_we = 1'b0; e_addr = m_last; e_din = 8'h00;
        if (rst) begin
            e_addr = '0;
            m_clear = 1'b0; m_idx = 0; m_ptr_rd = 1'b0;
            rq.delete();
        end else begin
            if (!m_clear && !bus.tg_we) begin
                if (bus.pw_req && bus.rd_req) begin
                    g_pw = !m_ptr_rd;
                    g_rd = m_ptr_rd;
                end else begin
                    g_pw = bus.pw_req;
                    g_rd = bus.rd_req;
                end
            end
            chk("pw_ready", 32'(bus.pw_ready), 32'(g_pw));
            chk("rd_ready", 32'(bus.rd_ready), 32'(g_rd));
            if (bus.tg_we) begin
                e_we = 1'b1; e_addr = bus.tg_addr; e_din = bus.tg_input;
            end else if (m_clear) begin
                e_we = 1'b1; e_addr = ADDR_W'(m_idx); e_din = 8'h00;
            end else if (g_pw) begin
                e_we = 1'b1; e_addr = bus.pw_addr; e_din = bus.pw_data;
                m_ptr_rd = 1'b1;
            end else if (g_rd) begin
                e_addr = bus.rd_addr;
                ent.due = cyc + 3;
                ent.data = shadow[bus.rd_addr];
                rq.push_back(ent);
                m_ptr_rd = 1'b0;
            end
            if (e_we) shadow[e_addr] = e_din;
            if (m_clear) begin
                if (!bus.tg_we) begin
                    if (m_idx == DEPTH - 1) m_clear = 1'b0;
                    else m_idx++;
                end
            end else if (bus.clear_start) begin
                m_clear = 1'b1;
                m_idx = 0;
            end
        end
        m_last = e_addr;
        @(posedge clk);
        #1;
        cyc++;
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        if (e_we || rst) chk("mem_din", 32'(bus.mem_din), 32'(e_din));
        chk("clear_busy", 32'(bus.clear_busy), 32'(m_clear));
        if (bus.mem_we) n_we++;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ent = rq.pop_front();
            chk("rd_valid", 32'(bus.rd_valid), 32'd1);
            chk("rd_data", 32'(bus.rd_data), 32'(ent.data));
        end else begin
            chk("rd_valid", 32'(bus.rd_valid), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        int we0;
        int bad;
        bit injected;
        bit restarted;

        rst = 1'b1;
        idle_in();
        @(negedge clk);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Terminal write beats both pending requesters
        bus.tg_we = 1'b1; bus.tg_addr = 15'h0010; bus.tg_input = 8'h41;
        bus.pw_req = 1'b1; bus.pw_addr = 15'h0020; bus.pw_data = 8'h55;
        bus.rd_req = 1'b1; bus.rd_addr = 15'h0010;
        tick();
        idle_in();

        // Preload 0..2 through terminal writes, then read them back-to-back
        for (int i = 0; i < 3; i++) begin
            bus.tg_we = 1'b1; bus.tg_addr = ADDR_W'(i); bus.tg_input = 8'(8'hA0 + i);
            tick();
        end
        idle_in();
        for (int i = 0; i < 3; i++) begin
            bus.rd_req = 1'b1; bus.rd_addr = ADDR_W'(i);
            tick();
        end
        idle_in();
        repeat (4) tick();

        // Contention: processor then read, alternating
        bus.pw_req = 1'b1; bus.pw_addr = 15'h0020; bus.pw_data = 8'h55;
        bus.rd_req = 1'b1; bus.rd_addr = 15'h0001;
        repeat (4) tick();
        idle_in();
        repeat (4) tick();

        // Full clear sweep with a terminal write stealing one slot and requesters held off
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        bus.pw_req = 1'b1; bus.pw_addr = 15'd100; bus.pw_data = 8'h77;
        bus.rd_req = 1'b1; bus.rd_addr = 15'd3;
        we0 = n_we;
        injected = 1'b0;
        restarted = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 20; i++) begin
            bus.tg_we = 1'b0;
            bus.clear_start = 1'b0;
            if (!injected && m_idx == 100) begin
                bus.tg_we = 1'b1; bus.tg_addr = 15'd5; bus.tg_input = 8'h42;
                injected = 1'b1;
            end else if (!restarted && m_idx == 200) begin
                bus.clear_start = 1'b1;
                restarted = 1'b1;
            end
            tick();
            if (!m_clear) break;
        end
        bus.tg_we = 1'b0;
        bus.clear_start = 1'b0;
        chk("sweep_writes", 32'(n_we - we0), 32'(DEPTH + 1));
        tick();
        idle_in();
        repeat (3) tick();
        chk("addr5_kept", 32'(bram[5]), 32'h42);
        chk("last_cleared", 32'(bram[DEPTH-1]), 32'h00);
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (bram[i] !== shadow[i]) bad++;
        chk("mem_image", 32'(bad), 32'd0);

        // Random mix of terminal, processor and read traffic
        for (int i = 0; i < 600; i++) begin
            bus.tg_we    = ($urandom_range(0, 3) == 0);
            bus.tg_addr  = ADDR_W'($urandom_range(0, 63));
            bus.tg_input = 8'($urandom);
            bus.pw_req   = ($urandom_range(0, 1) == 1);
            bus.pw_addr  = ADDR_W'($urandom_range(0, 63));
            bus.pw_data  = 8'($urandom);
            bus.rd_req   = ($urandom_range(0, 1) == 1);
            bus.rd_addr  = ADDR_W'($urandom_range(0, 63));
            tick();
        end
        idle_in();
        repeat (4) tick();

        // Reset with a read in flight
        bus.rd_req = 1'b1; bus.rd_addr = 15'd2;
        tick();
        idle_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();

        // Reset in the middle of a sweep
        bus.clear_start = 1'b1;
        tick();
        bus.clear_start = 1'b0;
        for (int i = 0; i < 600 && m_idx != 500; i++) tick();
        chk("sweep_at_500", 32'(bus.clear_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("busy_after_rst", 32'(bus.clear_busy), 32'd0);
        bus.pw_req = 1'b1; bus.pw_addr = 15'd7; bus.pw_data = 8'h11;
        bus.rd_req = 1'b1; bus.rd_addr = 15'd7;
        repeat (4) tick();
        idle_in();
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
